// File: rtl/branch_predictor.sv
// Tagged two-bit-counter branch predictor with a branch target buffer.
// It also detects mispredicts at EX and keeps saturating resolution statistics.
module branch_predictor #(
  parameter int IDX_BITS  = 6,
  parameter int TAG_BITS  = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          if_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_mispred
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [CNT_WIDTH-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_WIDTH-1:0] stat_mispred_q, stat_mispred_d;

  logic [IDX_BITS-1:0]  if_idx, ex_idx;
  logic [TAG_BITS-1:0]  if_tag, ex_tag;
  logic                 ex_hit;
  logic                 update;
  logic [1:0]           ctr_d;
  logic                 unused_pc_bits;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign unused_pc_bits = ^{if_pc, ex_pc};

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

  assign update      = ex_valid && ex_is_branch;
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign mispredict  = update &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  always_comb begin
    ctr_d = ctr_q[ex_idx];
    if (ex_taken) begin
      if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
    end else begin
      if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
    end
  end

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (update) begin
      if (stat_branches_q != '1) stat_branches_d = stat_branches_q + CNT_ONE;
      if (mispredict && (stat_mispred_q != '1)) stat_mispred_d = stat_mispred_q + CNT_ONE;
    end
  end

  // A not-taken miss leaves the table untouched so cold branches never evict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_d;
        if (ex_taken) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised self-checking bench for branch_predictor against a table model.
// Narrow statistics counters make saturation reachable in a short run.
module tb_branch_predictor;
  localparam int IDX_BITS  = 6;
  localparam int TAG_BITS  = 8;
  localparam int CNT_WIDTH = 4;
  localparam int ENTRIES   = 1 << IDX_BITS;
  localparam int STAT_MAX  = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] if_pc = '0;
  logic pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic mispredict;
  logic [31:0] redirect_pc;
  logic [CNT_WIDTH-1:0] stat_branches, stat_mispred;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_br, m_mis;
  int          tests_run = 0, tests_failed = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (IDX_BITS + 2)) % (1 << TAG_BITS));
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic logic m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic m_mispred();
    return ex_valid && ex_is_branch &&
           ((ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target)));
  endfunction

  function automatic void m_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    int i = idx_of(pc);
    if (m_hit(pc)) begin
      if (tk) begin m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1; m_tgt[i] = tgt; end
      else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end else if (tk) begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
    end
  endfunction

  task automatic set_ex(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0;
  endtask

  // One clock edge; the model absorbs whatever update was presented.
  task automatic step();
    logic upd, mp;
    upd = ex_valid && ex_is_branch;
    mp  = m_mispred();
    @(posedge clk);
    if (upd && rst_n) begin
      m_update(ex_pc, ex_taken, ex_target);
      if (m_br < STAT_MAX) m_br++;
      if (mp && m_mis < STAT_MAX) m_mis++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_pc = 32'h100; idle();
    m_reset();
    #12;
    tests_run++; if (pred_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hit got %b want 0", pred_hit); end
    tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_taken got %b want 0", pred_taken); end
    tests_run++; if (pred_target !== 32'h104) begin tests_failed++; $display("[TB] FAIL reset_target got %h want 00000104", pred_target); end
    tests_run++; if (stat_branches !== '0 || stat_mispred !== '0) begin tests_failed++; $display("[TB] FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispred); end
    rst_n = 1'b1;
  endtask

  task automatic test_alloc();
    set_ex(32'h100, 1'b1, 32'h80, 1'b0, 32'h104); if_pc = 32'h100;
    #1;
    tests_run++; if (mispredict !== 1'b1) begin tests_failed++; $display("[TB] FAIL alloc_mispredict got %b want 1", mispredict); end
    tests_run++; if (redirect_pc !== 32'h80) begin tests_failed++; $display("[TB] FAIL alloc_redirect got %h want 00000080", redirect_pc); end
    step(); idle(); #1;
    tests_run++; if (pred_taken !== 1'b1) begin tests_failed++; $display("[TB] FAIL alloc_taken got %b want 1", pred_taken); end
    tests_run++; if (pred_target !== 32'h80) begin tests_failed++; $display("[TB] FAIL alloc_target got %h want 00000080", pred_target); end
  endtask

  task automatic test_counter();
    logic outcome [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic want    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      set_ex(32'h100, outcome[k], 32'h80, m_taken(32'h100), m_target(32'h100));
      if_pc = 32'h100;
      step(); idle(); #1;
      tests_run++; if (pred_taken !== want[k]) begin tests_failed++; $display("[TB] FAIL counter_step%0d got %b want %b", k, pred_taken, want[k]); end
      tests_run++; if (pred_hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL counter_hit%0d got %b want 1", k, pred_hit); end
    end
  endtask

  task automatic test_not_taken_miss();
    set_ex(32'h200, 1'b0, 32'h400, 1'b0, 32'h204); if_pc = 32'h200;
    #1;
    tests_run++; if (mispredict !== 1'b0) begin tests_failed++; $display("[TB] FAIL ntmiss_mispredict got %b want 0", mispredict); end
    tests_run++; if (redirect_pc !== 32'h204) begin tests_failed++; $display("[TB] FAIL ntmiss_redirect got %h want 00000204", redirect_pc); end
    step(); idle(); #1;
    tests_run++; if (pred_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL ntmiss_noalloc got %b want 0", pred_hit); end
    if_pc = 32'h100; #1;
    tests_run++; if (pred_hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL ntmiss_keep got %b want 1", pred_hit); end
  endtask

  task automatic test_alias();
    set_ex(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    step(); idle(); if_pc = 32'h200; #1;
    tests_run++; if (pred_target !== 32'h300) begin tests_failed++; $display("[TB] FAIL alias_new got %h want 00000300", pred_target); end
    if_pc = 32'h100; #1;
    tests_run++; if (pred_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL alias_old_hit got %b want 0", pred_hit); end
    tests_run++; if (pred_target !== 32'h104) begin tests_failed++; $display("[TB] FAIL alias_old_target got %h want 00000104", pred_target); end
  endtask

  task automatic test_same_cycle();
    set_ex(32'h200, 1'b0, 32'h300, 1'b1, 32'h300); if_pc = 32'h200; #1;
    tests_run++; if (pred_taken !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_old_taken got %b want 1", pred_taken); end
    tests_run++; if (mispredict !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_mispredict got %b want 1", mispredict); end
    step(); idle(); #1;
    tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("[TB] FAIL same_new_taken got %b want 0", pred_taken); end
    set_ex(32'h400, 1'b1, 32'h40, 1'b0, 32'h404); if_pc = 32'h400; #1;
    tests_run++; if (pred_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL same_alloc_old got %b want 0", pred_hit); end
    step(); idle(); #1;
    tests_run++; if (pred_target !== 32'h40) begin tests_failed++; $display("[TB] FAIL same_alloc_new got %h want 00000040", pred_target); end
  endtask

  task automatic test_wrap();
    if_pc = 32'hFFFF_FFFC; set_ex(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b0, 32'h0); #1;
    tests_run++; if (pred_target !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_target got %h want 00000000", pred_target); end
    tests_run++; if (redirect_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_redirect got %h want 00000000", redirect_pc); end
    step(); idle();
  endtask

  task automatic test_saturation();
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_taken = 1'b1; ex_pred_taken = 1'b0; #1;
    tests_run++; if (mispredict !== 1'b0) begin tests_failed++; $display("[TB] FAIL nonbranch_mispredict got %b want 0", mispredict); end
    for (int k = 0; k < STAT_MAX + 4; k++) begin
      logic tk = 1'($urandom_range(1));
      set_ex(32'h600 + 32'(k * 4), tk, 32'h700, ~tk, 32'h700);
      step();
      tests_run++; if (stat_branches !== CNT_WIDTH'(m_br) || stat_mispred !== CNT_WIDTH'(m_mis)) begin
        tests_failed++; $display("[TB] FAIL sat_stats%0d got %0d/%0d want %0d/%0d", k, stat_branches, stat_mispred, m_br, m_mis);
      end
    end
    idle();
    tests_run++; if (stat_mispred !== '1) begin tests_failed++; $display("[TB] FAIL sat_mispred_hold got %0d want %0d", stat_mispred, STAT_MAX); end
    tests_run++; if (stat_branches !== '1) begin tests_failed++; $display("[TB] FAIL sat_branches_hold got %0d want %0d", stat_branches, STAT_MAX); end
  endtask

  function automatic logic [31:0] pool_pc();
    int idxs [3] = '{0, 1, 5};
    if ($urandom_range(15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(3, 1)) << (IDX_BITS + 2)) | (32'(idxs[$urandom_range(2)]) << 2);
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, tgt;
      logic tk, ptk;
      pc  = pool_pc();
      tk  = 1'($urandom_range(1));
      tgt = ($urandom_range(1) == 1) ? 32'h80 : {$urandom_range(255), 2'b00};
      if ($urandom_range(3) != 0) set_ex(pc, tk, tgt, m_taken(pc), m_target(pc));
      else begin ptk = 1'($urandom_range(1)); set_ex(pc, tk, tgt, ptk, ptk ? 32'h80 : pc + 32'd4); end
      ex_valid     = ($urandom_range(9) != 0);
      ex_is_branch = ($urandom_range(4) != 0);
      if_pc = ($urandom_range(1) == 1) ? pc : pool_pc();
      #1;
      tests_run++; if (pred_hit !== m_hit(if_pc) || pred_taken !== m_taken(if_pc) || pred_target !== m_target(if_pc)) begin
        tests_failed++; $display("[TB] FAIL rand_lookup%0d pc %h got %b%b %h want %b%b %h", n, if_pc, pred_hit, pred_taken, pred_target, m_hit(if_pc), m_taken(if_pc), m_target(if_pc));
      end
      tests_run++; if (mispredict !== m_mispred() || redirect_pc !== (tk ? tgt : pc + 32'd4)) begin
        tests_failed++; $display("[TB] FAIL rand_resolve%0d got %b %h want %b %h", n, mispredict, redirect_pc, m_mispred(), tk ? tgt : pc + 32'd4);
      end
      step();
      tests_run++; if (stat_branches !== CNT_WIDTH'(m_br) || stat_mispred !== CNT_WIDTH'(m_mis)) begin
        tests_failed++; $display("[TB] FAIL rand_stats%0d got %0d/%0d want %0d/%0d", n, stat_branches, stat_mispred, m_br, m_mis);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    set_ex(32'h500, 1'b1, 32'h900, 1'b0, 32'h504); if_pc = 32'h80;
    #2; rst_n = 1'b0; m_reset(); #1;
    tests_run++; if (pred_hit !== 1'b0 || stat_branches !== '0) begin tests_failed++; $display("[TB] FAIL midreset_state got %b %0d want 0 0", pred_hit, stat_branches); end
    tests_run++; if (mispredict !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_mispredict got %b want 1", mispredict); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; idle(); if_pc = 32'h500; #1;
    tests_run++; if (pred_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_dropped got %b want 0", pred_hit); end
    step();
    tests_run++; if (stat_branches !== '0 || stat_mispred !== '0) begin tests_failed++; $display("[TB] FAIL midreset_stats got %0d/%0d want 0/0", stat_branches, stat_mispred); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_not_taken_miss();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
